// File: rtl/scl_stall_pkg.sv
// Shared types and defaults for the SCL stall engine.
package scl_stall_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_STALL = 2'd1,
      ST_DONE  = 2'd2
   } stall_state_t;

   localparam int DEF_N_REQ = 2;
   localparam int DEF_CNT_W = 8;

   // Width of a binary requester index; never less than one bit.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/stall_arbiter.sv
// Fixed-priority selector: lowest-index active request wins.
module stall_arbiter #(
   parameter int N_REQ = 2,
   parameter int IDX_W = 1
) (
   input  logic [N_REQ-1:0] req,
   output logic [N_REQ-1:0] gnt,
   output logic [IDX_W-1:0] idx,
   output logic             any
);

   // Scan from the top down so the lowest set bit is the last one written.
   always_comb begin
      gnt = '0;
      idx = '0;
      any = 1'b0;
      for (int i = N_REQ - 1; i >= 0; i--) begin
         if (req[i]) begin
            gnt    = '0;
            gnt[i] = 1'b1;
            idx    = IDX_W'(i);
            any    = 1'b1;
         end
      end
   end

endmodule

// File: rtl/scl_stall_engine.sv
// SCL clock-stretch engine: grants one requester at a time and holds SCL
// low for the requested number of cycles, with abort and completion pulses.
//
// Handshake: i_req[k] is a level held until o_gnt[k] pulses; the requester
// drops it the following cycle. Requests and counts are only looked at in
// IDLE, and the winning count is latched on the grant edge.
module scl_stall_engine
   import scl_stall_pkg::*;
#(
   parameter int N_REQ = DEF_N_REQ,
   parameter int CNT_W = DEF_CNT_W
) (
   input  logic                   i_stall_clk,
   input  logic                   i_stall_rst_n,
   input  logic [N_REQ-1:0]       i_req,
   input  logic [N_REQ*CNT_W-1:0] i_cycles,
   input  logic                   i_abort,
   output logic [N_REQ-1:0]       o_gnt,
   output logic                   o_scl_stall,
   output logic [N_REQ-1:0]       o_done,
   output logic                   o_aborted,
   output logic                   o_busy,
   output logic [CNT_W-1:0]       o_remaining,
   output logic [1:0]             dbg_state
);

   localparam int IDX_W = idx_width(N_REQ);

   stall_state_t     state_q, state_d;
   logic [IDX_W-1:0] id_q, id_d;
   logic [CNT_W-1:0] rem_q, rem_d;
   logic             zero_q, zero_d;
   logic [N_REQ-1:0] gnt_q, gnt_d;
   logic [N_REQ-1:0] done_q, done_d;
   logic             aborted_q, aborted_d;
   logic             stall_q, stall_d;
   logic             busy_q, busy_d;

   logic [N_REQ-1:0] arb_gnt;
   logic [IDX_W-1:0] arb_idx;
   logic             arb_any;
   logic [CNT_W-1:0] sel_cnt;

   stall_arbiter #(
      .N_REQ (N_REQ),
      .IDX_W (IDX_W)
   ) u_arb (
      .req (i_req),
      .gnt (arb_gnt),
      .idx (arb_idx),
      .any (arb_any)
   );

   // Pick the count slice belonging to the arbitration winner.
   always_comb begin
      sel_cnt = '0;
      for (int k = 0; k < N_REQ; k++) begin
         if (arb_gnt[k]) sel_cnt = i_cycles[k*CNT_W +: CNT_W];
      end
   end

   // Next-state and registered-output computation.
   // A zero-count grant spends its grant cycle in DONE with zero_q set, and
   // pulses o_done on the following cycle so grant and done never overlap.
   always_comb begin
      state_d   = state_q;
      id_d      = id_q;
      rem_d     = rem_q;
      zero_d    = zero_q;
      gnt_d     = '0;
      done_d    = '0;
      aborted_d = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (arb_any) begin
               gnt_d = arb_gnt;
               id_d  = arb_idx;
               rem_d = sel_cnt;
               if (sel_cnt == '0) begin
                  state_d = ST_DONE;
                  zero_d  = 1'b1;
               end else begin
                  state_d = ST_STALL;
               end
            end
         end
         ST_STALL: begin
            if (i_abort) begin
               state_d   = ST_IDLE;
               rem_d     = '0;
               aborted_d = 1'b1;
            end else if (rem_q == CNT_W'(1)) begin
               state_d = ST_DONE;
               rem_d   = '0;
               done_d  = N_REQ'(1) << id_q;
            end else begin
               rem_d = rem_q - CNT_W'(1);
            end
         end
         ST_DONE: begin
            if (zero_q) begin
               zero_d = 1'b0;
               done_d = N_REQ'(1) << id_q;
            end else begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      stall_d = (state_d == ST_STALL);
      busy_d  = (state_d != ST_IDLE);
   end

   // State and output registers, cleared asynchronously.
   always_ff @(posedge i_stall_clk or negedge i_stall_rst_n) begin
      if (!i_stall_rst_n) begin
         state_q   <= ST_IDLE;
         id_q      <= '0;
         rem_q     <= '0;
         zero_q    <= 1'b0;
         gnt_q     <= '0;
         done_q    <= '0;
         aborted_q <= 1'b0;
         stall_q   <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         id_q      <= id_d;
         rem_q     <= rem_d;
         zero_q    <= zero_d;
         gnt_q     <= gnt_d;
         done_q    <= done_d;
         aborted_q <= aborted_d;
         stall_q   <= stall_d;
         busy_q    <= busy_d;
      end
   end

   assign o_gnt       = gnt_q;
   assign o_done      = done_q;
   assign o_aborted   = aborted_q;
   assign o_scl_stall = stall_q;
   assign o_busy      = busy_q;
   assign o_remaining = rem_q;
   assign dbg_state   = state_q;

endmodule

// File: tb/tb_scl_stall_engine.sv
// Bench for scl_stall_engine: transaction-level timeline model plus
// directed scenarios and a randomized multi-requester phase.
module tb_scl_stall_engine;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [1:0]  req = '0;
   logic [15:0] cycles = '0;
   logic        abort = 1'b0;
   logic [1:0]  gnt, done, dbg;
   logic        scl, aborted, busy;
   logic [7:0]  rem;

   int total = 0;
   int bad = 0;
   bit rand_mode = 1'b0;

   scl_stall_engine #(.N_REQ(2), .CNT_W(8)) dut (
      .i_stall_clk   (clk),
      .i_stall_rst_n (rst_n),
      .i_req         (req),
      .i_cycles      (cycles),
      .i_abort       (abort),
      .o_gnt         (gnt),
      .o_scl_stall   (scl),
      .o_done        (done),
      .o_aborted     (aborted),
      .o_busy        (busy),
      .o_remaining   (rem),
      .dbg_state     (dbg)
   );

   // clock / watchdog
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: run exceeded time limit");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act_v, input logic [31:0] exp_v);
      total++;
      if (act_v !== exp_v) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act_v, exp_v, $time);
      end
   endtask

   // ---------------- model ----------------
   // A transaction granted at edge e owns output slots e, e+1, ... (slot s is
   // the interval after edge s). With count n>0: grant at slot e, stall slots
   // e..e+n-1 with remaining n-d, done at slot e+n, next grant edge e+n+2.
   // With n=0: grant at e, done at e+1, next grant edge e+3.
   // An abort sampled at edge a while stalling: aborted pulse at slot a only,
   // next grant edge a+1.
   int edge_no = 0;
   bit act = 1'b0;
   int t_e = 0, t_n = 0, t_id = 0, t_abort = -1;
   int free_edge = 0;

   function automatic bit in_stall(input int s);
      return act && (t_abort < 0) && (t_n > 0) && (s >= t_e) && (s < t_e + t_n);
   endfunction

   always @(posedge clk) begin
      edge_no++;
      if (!rst_n) begin
         act = 1'b0;
         free_edge = edge_no + 1;
      end else if (abort && in_stall(edge_no - 1)) begin
         t_abort = edge_no;
         free_edge = edge_no + 1;
      end else if (edge_no >= free_edge && req != 2'b00) begin
         act = 1'b1;
         t_e = edge_no;
         t_id = req[0] ? 0 : 1;
         t_n = int'(cycles[t_id*8 +: 8]);
         t_abort = -1;
         free_edge = (t_n == 0) ? edge_no + 3 : edge_no + t_n + 2;
      end
   end

   // ---------------- scoreboard / observation ----------------
   int clr_gen = 0, seen_gen = 0;
   int stall_cnt, busy_cnt, gnt_cnt, done_cnt, aborted_cnt;
   int first_gnt_slot, last_gnt_slot, last_done_slot;
   logic [1:0] first_gnt_vec, last_gnt_vec, last_done_vec;

   always @(negedge clk) begin : compare_blk
      logic [1:0] eg, ed;
      logic       es, ea, eb;
      logic [7:0] er;
      int         d;
      eg = '0; ed = '0; es = 1'b0; ea = 1'b0; eb = 1'b0; er = '0;
      if (rst_n && act) begin
         d = edge_no - t_e;
         if (t_abort >= 0 && edge_no >= t_abort) begin
            ea = (edge_no == t_abort);
         end else begin
            if (d == 0) eg[t_id] = 1'b1;
            if (t_n > 0) begin
               es = (d < t_n);
               er = es ? 8'(t_n - d) : 8'd0;
               ed[t_id] = (d == t_n);
               eb = (d <= t_n);
            end else begin
               ed[t_id] = (d == 1);
               eb = (d <= 1);
            end
         end
      end
      chk("gnt", {30'd0, gnt}, {30'd0, eg});
      chk("scl_stall", {31'd0, scl}, {31'd0, es});
      chk("done", {30'd0, done}, {30'd0, ed});
      chk("aborted", {31'd0, aborted}, {31'd0, ea});
      chk("busy", {31'd0, busy}, {31'd0, eb});
      chk("remaining", {24'd0, rem}, {24'd0, er});

      if (seen_gen != clr_gen) begin
         seen_gen = clr_gen;
         stall_cnt = 0; busy_cnt = 0; gnt_cnt = 0; done_cnt = 0; aborted_cnt = 0;
         first_gnt_slot = -1; last_gnt_slot = -1; last_done_slot = -1;
         first_gnt_vec = '0; last_gnt_vec = '0; last_done_vec = '0;
      end
      if (scl) stall_cnt++;
      if (busy) busy_cnt++;
      if (aborted) aborted_cnt++;
      if (gnt != 2'b00) begin
         gnt_cnt++;
         if (gnt_cnt == 1) begin
            first_gnt_slot = edge_no;
            first_gnt_vec = gnt;
         end
         last_gnt_slot = edge_no;
         last_gnt_vec = gnt;
      end
      if (done != 2'b00) begin
         done_cnt++;
         last_done_slot = edge_no;
         last_done_vec = done;
      end
   end

   // ---------------- driver tasks ----------------
   function automatic logic [7:0] pick_cnt();
      if ($urandom_range(0, 4) == 0) return 8'd0;
      if ($urandom_range(0, 15) == 0) return 8'd40;
      return 8'($urandom_range(1, 12));
   endfunction

   // One cycle: wait past the falling edge, retire granted requests and,
   // in random mode, perturb requests, counts, abort and reset.
   task automatic step(input int n);
      logic [1:0] dropped;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         #1;
         dropped = req & gnt;
         req = req & ~gnt;
         if (rand_mode) begin
            if (!rst_n) rst_n = 1'b1;
            else if ($urandom_range(0, 399) == 0) rst_n = 1'b0;
            for (int k = 0; k < 2; k++) begin
               if (req[k] && $urandom_range(0, 39) == 0) begin
                  req[k] = 1'b0;
               end else if (!req[k] && !dropped[k] && $urandom_range(0, 5) == 0) begin
                  req[k] = 1'b1;
                  cycles[k*8 +: 8] = pick_cnt();
               end else if (!req[k]) begin
                  cycles[k*8 +: 8] = 8'($urandom);
               end
            end
            abort = ($urandom_range(0, 19) == 0);
         end
      end
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while ((busy || gnt != 2'b00 || done != 2'b00 || aborted) && n < 400) begin
         step(1);
         n++;
      end
      chk("idle_reached", (n < 400) ? 32'd1 : 32'd0, 32'd1);
      step(2);
   endtask

   task automatic clear_obs();
      clr_gen++;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      step(3);
      chk("rst_gnt", {30'd0, gnt}, 32'd0);
      chk("rst_scl", {31'd0, scl}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_rem", {24'd0, rem}, 32'd0);
      chk("rst_state", {30'd0, dbg}, 32'd0);
      rst_n = 1'b1;
      step(2);

      // single requester, five stall cycles
      wait_idle();
      clear_obs();
      cycles = {8'd0, 8'd5};
      req = 2'b01;
      step(1);
      chk("t1_gnt", {30'd0, gnt}, 32'd1);
      chk("t1_rem_first", {24'd0, rem}, 32'd5);
      step(12);
      chk("t1_stall_len", stall_cnt, 32'd5);
      chk("t1_done_vec", {30'd0, last_done_vec}, 32'd1);
      chk("t1_done_gap", last_done_slot - first_gnt_slot, 32'd5);

      // both request, priority and back-to-back spacing
      wait_idle();
      clear_obs();
      cycles = {8'd7, 8'd3};
      req = 2'b11;
      step(25);
      chk("t2_first_vec", {30'd0, first_gnt_vec}, 32'd1);
      chk("t2_second_vec", {30'd0, last_gnt_vec}, 32'd2);
      chk("t2_gnt_gap", last_gnt_slot - first_gnt_slot, 32'd5);
      chk("t2_stall_len", stall_cnt, 32'd10);
      chk("t2_done_cnt", done_cnt, 32'd2);
      chk("t2_done_vec", {30'd0, last_done_vec}, 32'd2);

      // zero-count request
      wait_idle();
      clear_obs();
      cycles = {8'd9, 8'd0};
      req = 2'b01;
      step(8);
      chk("t3_gnt_cnt", gnt_cnt, 32'd1);
      chk("t3_done_cnt", done_cnt, 32'd1);
      chk("t3_stall_len", stall_cnt, 32'd0);
      chk("t3_busy_len", busy_cnt, 32'd2);
      chk("t3_done_gap", last_done_slot - first_gnt_slot, 32'd1);

      // abort on the fourth stall cycle of ten
      wait_idle();
      clear_obs();
      cycles = {8'd0, 8'd10};
      req = 2'b01;
      step(1);
      step(3);
      chk("t4_rem_4th", {24'd0, rem}, 32'd7);
      abort = 1'b1;
      step(1);
      abort = 1'b0;
      chk("t4_scl_low", {31'd0, scl}, 32'd0);
      chk("t4_aborted", {31'd0, aborted}, 32'd1);
      chk("t4_busy_low", {31'd0, busy}, 32'd0);
      step(15);
      chk("t4_done_cnt", done_cnt, 32'd0);
      chk("t4_abort_cnt", aborted_cnt, 32'd1);
      chk("t4_stall_len", stall_cnt, 32'd4);

      // abort coincident with the final stall cycle
      wait_idle();
      clear_obs();
      cycles = {8'd0, 8'd4};
      req = 2'b01;
      step(1);
      step(3);
      chk("t6_rem_last", {24'd0, rem}, 32'd1);
      abort = 1'b1;
      step(1);
      abort = 1'b0;
      chk("t6_aborted", {31'd0, aborted}, 32'd1);
      chk("t6_done_now", {30'd0, done}, 32'd0);
      step(6);
      chk("t6_done_cnt", done_cnt, 32'd0);
      chk("t6_abort_cnt", aborted_cnt, 32'd1);

      // reset in the middle of a 255-cycle stall, then a full stall
      wait_idle();
      cycles = {8'd0, 8'd255};
      req = 2'b01;
      step(1);
      step(99);
      chk("t5_scl_before", {31'd0, scl}, 32'd1);
      rst_n = 1'b0;
      #1;
      chk("t5_rst_scl", {31'd0, scl}, 32'd0);
      chk("t5_rst_busy", {31'd0, busy}, 32'd0);
      chk("t5_rst_rem", {24'd0, rem}, 32'd0);
      chk("t5_rst_gnt", {30'd0, gnt}, 32'd0);
      chk("t5_rst_done", {30'd0, done}, 32'd0);
      chk("t5_rst_abt", {31'd0, aborted}, 32'd0);
      clear_obs();
      step(3);
      chk("t5_no_done", done_cnt, 32'd0);
      chk("t5_no_abort", aborted_cnt, 32'd0);
      clear_obs();
      req = 2'b01;
      rst_n = 1'b1;
      step(1);
      chk("t5_first_gnt", {30'd0, gnt}, 32'd1);
      step(270);
      chk("t5_stall_len", stall_cnt, 32'd255);
      chk("t5_done_cnt", done_cnt, 32'd1);
      chk("t5_done_gap", last_done_slot - first_gnt_slot, 32'd255);

      // randomized phase
      wait_idle();
      rand_mode = 1'b1;
      step(3000);
      rand_mode = 1'b0;
      req = 2'b00;
      abort = 1'b0;
      rst_n = 1'b1;
      step(60);
      wait_idle();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/scl_stall_engine.md
SCL_STALL_ENGINE -- requirements
Module: scl_stall_engine

Interface
REQ-001 SHALL provide parameter N_REQ, default 2, number of independent stall requesters (1..8).
REQ-002 SHALL provide parameter CNT_W, default 8, width of each requested stall-cycle count.
REQ-003 SHALL provide i_stall_clk  input  1  block clock; all state changes on its rising edge.
REQ-004 SHALL provide i_stall_rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL provide i_req  input  N_REQ  per-requester stall request, level, held until granted.
REQ-006 SHALL provide i_cycles  input  N_REQ*CNT_W  packed stall counts; slice k belongs to requester k.
REQ-007 SHALL provide i_abort  input  1  terminates an active stall.
REQ-008 SHALL provide o_gnt  output  N_REQ  one-hot, one-cycle grant pulse.
REQ-009 SHALL provide o_scl_stall  output  1  SCL hold-off, high while stalling.
REQ-010 SHALL provide o_done  output  N_REQ  one-hot, one-cycle completion pulse to the granted requester.
REQ-011 SHALL provide o_aborted  output  1  one-cycle pulse on abort completion.
REQ-012 SHALL provide o_busy  output  1  high in any state other than IDLE.
REQ-013 SHALL provide o_remaining  output  CNT_W  stall cycles still outstanding; 0 when idle.

Function
REQ-014 FSM states SHALL be IDLE, STALL, DONE; all outputs registered.
REQ-015 In IDLE, when any i_req bit is high at edge k, the lowest-index requester SHALL win; at k+1 o_gnt[id]=1 for one cycle and its i_cycles slice is latched.
REQ-016 Latched count N>0: state STALL at k+1; o_scl_stall high for exactly N cycles (k+1..k+N); o_remaining = N at k+1, decrementing by 1 per cycle.
REQ-017 After the Nth stall cycle the FSM SHALL enter DONE: o_scl_stall=0, o_done[id]=1 for one cycle, o_remaining=0.
REQ-018 Latched count N=0: FSM SHALL go IDLE->DONE directly; o_scl_stall never asserts; o_gnt and o_done both pulse (gnt at k+1, done at k+2).
REQ-019 DONE SHALL last one cycle then return to IDLE; a new grant therefore occurs no earlier than two cycles after o_done, guaranteeing at least one SCL-release cycle between back-to-back stalls.
REQ-020 i_req and i_cycles SHALL be ignored outside IDLE; changes to i_cycles after grant SHALL not affect the active stall.
REQ-021 A requester deasserting i_req before grant SHALL be treated as withdrawn; no grant issued.
REQ-022 A requester SHALL deassert i_req the cycle after o_gnt; a level still high when IDLE is re-entered is a new request.
REQ-023 i_abort high in STALL SHALL force o_scl_stall=0 next cycle, pulse o_aborted, suppress o_done, return to IDLE directly.
REQ-024 i_abort in IDLE or DONE SHALL be ignored; in DONE the completion stands.
REQ-025 i_abort on the same edge as the final stall cycle SHALL take priority: aborted, not done.
REQ-026 Count arithmetic SHALL be unsigned CNT_W bits; maximum stall 2^CNT_W-1 cycles; no wrap.

Reset
REQ-027 Asserting i_stall_rst_n low SHALL immediately force IDLE, o_scl_stall=0, o_gnt=0, o_done=0, o_aborted=0, o_busy=0, o_remaining=0, regardless of state.
REQ-028 Reset mid-stall SHALL release SCL without done/aborted pulse; first grant possible at the second edge after deassertion.

Structure
REQ-029 Shared package scl_stall_pkg SHALL hold the state enum and default N_REQ/CNT_W constants.
REQ-030 Fixed-priority selection SHALL be a sub-module stall_arbiter (N_REQ request vector in, one-hot grant and binary index out, combinational).

Verification
REQ-031 N_REQ=2, CNT_W=8: i_req[0] with cycles=5 -> o_gnt[0] at k+1, o_scl_stall high 5 cycles, o_done[0] at k+6.
REQ-032 i_req=2'b11, cycles {3,7} -> requester 0 served first (3 cycles), requester 1 granted k+6, stalls 7, o_done[1] pulses.
REQ-033 cycles=0 -> o_gnt then o_done, o_scl_stall never high, o_busy high 2 cycles.
REQ-034 cycles=10, i_abort at 4th stall cycle -> o_scl_stall low next cycle, o_aborted pulse, no o_done, o_busy low.
REQ-035 cycles=255 with reset asserted at cycle 100 -> all outputs 0 immediately, no pulses; new request after release stalls full 255.
REQ-036 cycles=4, i_abort coincident with final stall cycle -> o_aborted pulses, o_done stays 0.
